byte_data_memory: RTL and testbench
===================================

# byte_data_memory

Byte-addressed, single-port data memory for the CPU load/store path; the parametrised successor to the word-only data memory. Supports byte, halfword and word accesses with sign or zero extension, per-lane writes, misalignment detection and a valid/ready request handshake. It replaces the reset-time bulk clear with a sequential clear engine. Sits between the execute-stage load/store unit and the writeback mux.

## Interface
- ADDR_WIDTH, 12, byte-address width; depth DEPTH = 2^(ADDR_WIDTH-2) 32-bit words
- CLEAR_ON_RESET, 1, 1 = zero every word after reset; 0 = contents undefined, ready immediately
- clk  in  1  clock, all state on rising edge
- reset  in  1  reset, synchronous, active-high
- req_valid  in  1  request present
- req_ready  out  1  block accepts a request this cycle
- req_write  in  1  1 = store, 0 = load
- req_size  in  2  00 byte, 01 half, 10 word, 11 illegal
- req_unsigned  in  1  loads only: 1 = zero-extend, 0 = sign-extend
- req_addr  in  ADDR_WIDTH  byte address
- req_wdata  in  32  store data, right-aligned (bits [7:0] for byte, [15:0] for half)
- rsp_valid  out  1  one-cycle response pulse, every accepted request
- rsp_rdata  out  32  extended load data; 0 for stores and errors
- rsp_error  out  1  accepted request was misaligned or illegal size
- busy  out  1  clear engine running

## Operation
- States: CLEAR, READY. reset=1 → CLEAR if CLEAR_ON_RESET, else READY; clear index ← 0.
- CLEAR: one word per cycle, mem[idx] ← 0, idx++; on the edge that writes word DEPTH-1 → READY. req_ready=0, busy=1. Requests ignored, no response.
- READY: req_ready=1, busy=0. Accept = req_valid & req_ready.
- Word index = req_addr[ADDR_WIDTH-1:2]; lane = req_addr[1:0].
- Alignment: half needs addr[0]=0; word needs addr[1:0]=00; size 11 always errors. On error: no write, rsp_error=1, rsp_rdata=0.
- Store: byte enables from size/lane (byte → 1 lane, half → lanes {1:0} or {3:2}, word → all). Data replicated into selected lanes; unselected bytes unchanged.
- Load: select the lane bytes, shift to bit 0, extend per req_unsigned from bit 7 (byte) or 15 (half). Word ignores req_unsigned.
- Stores also produce rsp_valid=1, rsp_error as computed, rsp_rdata=0.
- Single port: one access per cycle. No response backpressure; the consumer must take rsp_* in the pulse cycle.
- Reset mid-operation: a pending response is dropped (rsp_valid=0 on the next edge). A clear in progress restarts from index 0.

## Timing
- Reset values: req_ready = !CLEAR_ON_RESET, busy = CLEAR_ON_RESET, rsp_valid=0, rsp_error=0, rsp_rdata=0.
- With CLEAR_ON_RESET=1, req_ready rises exactly DEPTH cycles after the first edge with reset low.
- req_ready depends on state only, never on req_valid.
- Latency: request accepted at edge N → rsp_* valid during cycle N to N+1 (registered), then low unless another request was accepted.
- Throughput: 1 request per cycle; back-to-back gives a continuous rsp_valid.
- Stores commit at the accept edge. A load in the next cycle to the same word returns the new data.
- Memory read is synchronous (registered), so it is block-RAM inferable. Extension and masking are applied to the registered word using a registered lane, size and unsigned flag.

## Structure
- Package dmem_pkg: size encodings SIZE_B/SIZE_H/SIZE_W, state enum {CLEAR, READY}, function for byte-enable generation.
- Sub-module dmem_lane_align: combinational; store byte-enable, lane replication and misalignment flag on the request side; lane extract and sign/zero extension on the response side.
- Top: FSM, clear counter, RAM array, response registers.

## Test plan
- Reset with CLEAR_ON_RESET=1, ADDR_WIDTH=6 → busy=1 for 16 cycles, req_ready rises in cycle 16, then load from every address returns 0.
- SW 0x8899AABB @0x10; LB @0x10 → 0xFFFFFFBB; LBU @0x13 → 0x00000088; LH @0x12 → 0xFFFF8899; LHU @0x10 → 0x0000AABB.
- SW 0x11223344 @0x20, SB 0xEE @0x21, SH 0x5566 @0x22 → LW @0x20 = 0x5566EE44.
- LW @0x22, SH @0x23, size 11 @0x00 → rsp_error=1, rsp_rdata=0, memory unchanged.
- Back-to-back SW 0xCAFEF00D @0x30 then LW @0x30 → rsp_valid high 2 cycles, second rdata 0xCAFEF00D.
- reset asserted during CLEAR and in the cycle after an accepted load → no rsp_valid, clear restarts and takes the full DEPTH cycles.

Source files
------------

// File: rtl/dmem_pkg.sv
// Shared encodings and helpers for the byte-addressed data memory.
// Latency: none (types, constants and pure functions only).
// Backpressure: not applicable.
package dmem_pkg;

    localparam logic [1:0] SIZE_B = 2'b00;
    localparam logic [1:0] SIZE_H = 2'b01;
    localparam logic [1:0] SIZE_W = 2'b10;
    localparam logic [1:0] SIZE_X = 2'b11;

    typedef enum logic {
        CLEAR = 1'b0,
        READY = 1'b1
    } state_t;

    // Byte lanes touched by an access of the given size at the given lane.
    function automatic logic [3:0] byte_enable(input logic [1:0] size, input logic [1:0] lane);
        logic [3:0] be;
        be = 4'b0000;
        case (size)
            SIZE_B:  be = 4'b0001 << lane;
            SIZE_H:  be = lane[1] ? 4'b1100 : 4'b0011;
            SIZE_W:  be = 4'b1111;
            default: be = 4'b0000;
        endcase
        return be;
    endfunction

    // Half accesses must be 2-byte aligned, words 4-byte aligned; size 11 never works.
    function automatic logic access_error(input logic [1:0] size, input logic [1:0] lane);
        logic err;
        err = 1'b0;
        case (size)
            SIZE_B:  err = 1'b0;
            SIZE_H:  err = lane[0];
            SIZE_W:  err = |lane;
            default: err = 1'b1;
        endcase
        return err;
    endfunction

endpackage

// File: rtl/dmem_lane_align.sv
// Lane steering: store byte enables/replication/error on the request side, lane extract + extension on the response side.
// Latency: purely combinational.
// Backpressure: none; follows its inputs every cycle.
module dmem_lane_align
    import dmem_pkg::*;
(
    input  logic [1:0]  req_size,
    input  logic [1:0]  req_lane,
    input  logic [31:0] req_wdata,
    output logic [3:0]  wr_be,
    output logic [31:0] wr_data,
    output logic        req_error,
    input  logic [31:0] rd_word,
    input  logic [1:0]  rd_lane,
    input  logic [1:0]  rd_size,
    input  logic        rd_unsigned,
    output logic [31:0] rd_data
);

    logic [31:0] rd_shifted;

    // Request side: flag bad accesses and suppress every enable for them.
    always_comb begin
        req_error = access_error(req_size, req_lane);
        wr_be     = req_error ? 4'b0000 : byte_enable(req_size, req_lane);
        case (req_size)
            SIZE_B:  wr_data = {4{req_wdata[7:0]}};
            SIZE_H:  wr_data = {2{req_wdata[15:0]}};
            default: wr_data = req_wdata;
        endcase
    end

    // Response side: shift the addressed lane down to bit 0, then extend.
    always_comb begin
        rd_shifted = rd_word >> {rd_lane, 3'b000};
        case (rd_size)
            SIZE_B:  rd_data = {{24{~rd_unsigned & rd_shifted[7]}}, rd_shifted[7:0]};
            SIZE_H:  rd_data = {{16{~rd_unsigned & rd_shifted[15]}}, rd_shifted[15:0]};
            SIZE_W:  rd_data = rd_word;
            default: rd_data = 32'h0;
        endcase
    end

endmodule

// File: rtl/byte_data_memory.sv
// Byte-addressed single-port data memory with byte/half/word loads and stores and a post-reset clear engine.
// Latency: request accepted at edge N, response registered and valid for the one cycle after N.
// Backpressure: req_ready low only while clearing; responses cannot be stalled.
module byte_data_memory
    import dmem_pkg::*;
#(
    parameter int ADDR_WIDTH     = 12,
    parameter bit CLEAR_ON_RESET = 1'b1
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic                  req_write,
    input  logic [1:0]            req_size,
    input  logic                  req_unsigned,
    input  logic [ADDR_WIDTH-1:0] req_addr,
    input  logic [31:0]           req_wdata,
    output logic                  rsp_valid,
    output logic [31:0]           rsp_rdata,
    output logic                  rsp_error,
    output logic                  busy
);

    localparam int WORD_BITS = ADDR_WIDTH - 2;
    localparam int DEPTH     = 1 << WORD_BITS;

    state_t state_q, state_d;
    logic [WORD_BITS-1:0] clr_idx_q;
    logic [WORD_BITS-1:0] word_idx;
    logic [1:0]  lane;

    logic [31:0] mem [DEPTH];
    logic [31:0] rd_word_q;

    logic [3:0]  wr_be;
    logic [31:0] wr_data;
    logic        req_error;
    logic [31:0] rd_data;

    logic        accept;
    logic        clr_we;
    logic        st_we;
    logic        ld_re;

    logic        rsp_load_q;
    logic [1:0]  rsp_lane_q;
    logic [1:0]  rsp_size_q;
    logic        rsp_unsigned_q;

    assign word_idx = req_addr[ADDR_WIDTH-1:2];
    assign lane     = req_addr[1:0];

    // State register; reset lands in CLEAR only when the clear engine is enabled.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= CLEAR_ON_RESET ? CLEAR : READY;
        end else begin
            state_q <= state_d;
        end
    end

    // Next state and handshake outputs; ready is a function of state alone.
    always_comb begin
        state_d   = state_q;
        req_ready = 1'b0;
        busy      = 1'b0;
        case (state_q)
            CLEAR: begin
                busy = 1'b1;
                if (&clr_idx_q) begin
                    state_d = READY;
                end
            end
            READY: begin
                req_ready = 1'b1;
            end
            default: state_d = READY;
        endcase
    end

    // Clear index walks every word; reset restarts it from zero.
    always_ff @(posedge clk) begin
        if (reset) begin
            clr_idx_q <= '0;
        end else if (busy) begin
            clr_idx_q <= clr_idx_q + WORD_BITS'(1);
        end
    end

    dmem_lane_align u_align (
        .req_size    (req_size),
        .req_lane    (lane),
        .req_wdata   (req_wdata),
        .wr_be       (wr_be),
        .wr_data     (wr_data),
        .req_error   (req_error),
        .rd_word     (rd_word_q),
        .rd_lane     (rsp_lane_q),
        .rd_size     (rsp_size_q),
        .rd_unsigned (rsp_unsigned_q),
        .rd_data     (rd_data)
    );

    // Reset wins over a request presented on the same edge.
    assign accept = req_valid & req_ready & ~reset;
    assign clr_we = busy & ~reset;
    assign st_we  = accept & req_write & ~req_error;
    assign ld_re  = accept & ~req_write & ~req_error;

    // Single RAM port: clear writes, byte-lane stores, synchronous reads (read-before-write).
    always_ff @(posedge clk) begin
        if (clr_we) begin
            mem[clr_idx_q] <= 32'h0;
        end else if (st_we) begin
            for (int i = 0; i < 4; i++) begin
                if (wr_be[i]) begin
                    mem[word_idx][8*i +: 8] <= wr_data[8*i +: 8];
                end
            end
        end
        if (ld_re) begin
            rd_word_q <= mem[word_idx];
        end
    end

    // Response pulse plus the lane/size/extension context needed to shape the read word.
    always_ff @(posedge clk) begin
        if (reset) begin
            rsp_valid      <= 1'b0;
            rsp_error      <= 1'b0;
            rsp_load_q     <= 1'b0;
            rsp_lane_q     <= 2'b00;
            rsp_size_q     <= SIZE_W;
            rsp_unsigned_q <= 1'b0;
        end else begin
            rsp_valid      <= accept;
            rsp_error      <= accept & req_error;
            rsp_load_q     <= ld_re;
            rsp_lane_q     <= lane;
            rsp_size_q     <= req_size;
            rsp_unsigned_q <= req_unsigned;
        end
    end

    // Stores, errors and idle cycles all present zero data.
    assign rsp_rdata = rsp_load_q ? rd_data : 32'h0;

endmodule

// File: tb/tb_byte_data_memory.sv
module tb_byte_data_memory;

    localparam int AW = 6;

    logic          clk = 1'b0;
    logic          reset;
    logic          req_valid;
    logic          req_ready;
    logic          req_write;
    logic [1:0]    req_size;
    logic          req_unsigned;
    logic [AW-1:0] req_addr;
    logic [31:0]   req_wdata;
    logic          rsp_valid;
    logic [31:0]   rsp_rdata;
    logic          rsp_error;
    logic          busy;

    int checks   = 0;
    int failures = 0;

    byte_data_memory #(.ADDR_WIDTH(AW), .CLEAR_ON_RESET(1'b1)) dut (
        .clk          (clk),
        .reset        (reset),
        .req_valid    (req_valid),
        .req_ready    (req_ready),
        .req_write    (req_write),
        .req_size     (req_size),
        .req_unsigned (req_unsigned),
        .req_addr     (req_addr),
        .req_wdata    (req_wdata),
        .rsp_valid    (rsp_valid),
        .rsp_rdata    (rsp_rdata),
        .rsp_error    (rsp_error),
        .busy         (busy)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // One request, one edge, then check the response pulse.
    task automatic access(input string tag, input logic w, input logic [1:0] sz, input logic uns,
                          input logic [AW-1:0] a, input logic [31:0] wd,
                          input logic exp_err, input logic [31:0] exp_dat);
        req_valid    = 1'b1;
        req_write    = w;
        req_size     = sz;
        req_unsigned = uns;
        req_addr     = a;
        req_wdata    = wd;
        @(posedge clk); #1;
        chk({tag, "_vld"}, {31'h0, rsp_valid}, 32'h1);
        chk({tag, "_err"}, {31'h0, rsp_error}, {31'h0, exp_err});
        chk({tag, "_dat"}, rsp_rdata, exp_dat);
        req_valid = 1'b0;
    endtask

    // Count edges after reset release; busy must hold for exactly 16 of them.
    task automatic run_clear(input string tag);
        chk({tag, "_busy0"}, {31'h0, busy}, 32'h1);
        chk({tag, "_rdy0"}, {31'h0, req_ready}, 32'h0);
        for (int k = 1; k <= 16; k++) begin
            @(posedge clk); #1;
            chk({tag, "_busy"}, {31'h0, busy}, (k < 16) ? 32'h1 : 32'h0);
            chk({tag, "_rdy"}, {31'h0, req_ready}, (k < 16) ? 32'h0 : 32'h1);
            chk({tag, "_rvld"}, {31'h0, rsp_valid}, 32'h0);
        end
    endtask

    initial begin
        reset        = 1'b1;
        req_valid    = 1'b0;
        req_write    = 1'b0;
        req_size     = 2'b10;
        req_unsigned = 1'b0;
        req_addr     = '0;
        req_wdata    = 32'h0;

        @(posedge clk); #1;
        @(posedge clk); #1;
        chk("rst_ready", {31'h0, req_ready}, 32'h0);
        chk("rst_busy", {31'h0, busy}, 32'h1);
        chk("rst_rvld", {31'h0, rsp_valid}, 32'h0);
        chk("rst_rerr", {31'h0, rsp_error}, 32'h0);
        chk("rst_rdat", rsp_rdata, 32'h0);

        reset = 1'b0;
        run_clear("clr1");

        // Every word reads zero after the clear.
        for (int a = 0; a < 64; a += 4) begin
            access("zero_lw", 1'b0, 2'b10, 1'b0, AW'(a), 32'h0, 1'b0, 32'h0);
        end

        // Idle in READY: ready stays high with no request.
        @(posedge clk); #1;
        chk("idle_rdy", {31'h0, req_ready}, 32'h1);
        chk("idle_rvld", {31'h0, rsp_valid}, 32'h0);

        // Lane extract and extension.
        access("sw10",  1'b1, 2'b10, 1'b0, 6'h10, 32'h8899AABB, 1'b0, 32'h0);
        access("lb10",  1'b0, 2'b00, 1'b0, 6'h10, 32'h0, 1'b0, 32'hFFFFFFBB);
        access("lbu13", 1'b0, 2'b00, 1'b1, 6'h13, 32'h0, 1'b0, 32'h00000088);
        access("lh12",  1'b0, 2'b01, 1'b0, 6'h12, 32'h0, 1'b0, 32'hFFFF8899);
        access("lhu10", 1'b0, 2'b01, 1'b1, 6'h10, 32'h0, 1'b0, 32'h0000AABB);
        access("lbu11", 1'b0, 2'b00, 1'b1, 6'h11, 32'h0, 1'b0, 32'h000000AA);
        access("lwu10", 1'b0, 2'b10, 1'b1, 6'h10, 32'h0, 1'b0, 32'h8899AABB);

        // Partial stores merge into the word.
        access("sw20",  1'b1, 2'b10, 1'b0, 6'h20, 32'h11223344, 1'b0, 32'h0);
        access("sb21",  1'b1, 2'b00, 1'b0, 6'h21, 32'h000000EE, 1'b0, 32'h0);
        access("sh22",  1'b1, 2'b01, 1'b0, 6'h22, 32'h00005566, 1'b0, 32'h0);
        access("lw20",  1'b0, 2'b10, 1'b0, 6'h20, 32'h0, 1'b0, 32'h5566EE44);

        // Misaligned and illegal-size accesses error out and write nothing.
        access("lw22_err", 1'b0, 2'b10, 1'b0, 6'h22, 32'h0, 1'b1, 32'h0);
        access("sh23_err", 1'b1, 2'b01, 1'b0, 6'h23, 32'h0000FFFF, 1'b1, 32'h0);
        access("sx00_err", 1'b1, 2'b11, 1'b0, 6'h00, 32'hFFFFFFFF, 1'b1, 32'h0);
        access("lx00_err", 1'b0, 2'b11, 1'b0, 6'h00, 32'h0, 1'b1, 32'h0);
        access("lw20_kept", 1'b0, 2'b10, 1'b0, 6'h20, 32'h0, 1'b0, 32'h5566EE44);
        access("lw00_kept", 1'b0, 2'b10, 1'b0, 6'h00, 32'h0, 1'b0, 32'h0);

        // Back-to-back store then load: continuous pulse, new data visible.
        access("b2b_sw30", 1'b1, 2'b10, 1'b0, 6'h30, 32'hCAFEF00D, 1'b0, 32'h0);
        access("b2b_lw30", 1'b0, 2'b10, 1'b0, 6'h30, 32'h0, 1'b0, 32'hCAFEF00D);
        @(posedge clk); #1;
        chk("b2b_after_vld", {31'h0, rsp_valid}, 32'h0);

        // Accepted load, then reset in the response cycle: next edge drops it.
        access("rst_ld", 1'b0, 2'b10, 1'b0, 6'h30, 32'h0, 1'b0, 32'hCAFEF00D);
        reset     = 1'b1;
        req_valid = 1'b1;
        @(posedge clk); #1;
        chk("rst_ld_vld", {31'h0, rsp_valid}, 32'h0);
        chk("rst_ld_dat", rsp_rdata, 32'h0);
        chk("rst_ld_busy", {31'h0, busy}, 32'h1);
        req_valid = 1'b0;

        // Release, clear a few words, then reset mid-clear; a store during clear is ignored.
        reset = 1'b0;
        for (int k = 0; k < 5; k++) begin
            req_valid = 1'b1;
            req_write = 1'b1;
            req_size  = 2'b10;
            req_addr  = 6'h04;
            req_wdata = 32'hDEADBEEF;
            @(posedge clk); #1;
            chk("clr_req_vld", {31'h0, rsp_valid}, 32'h0);
            chk("clr_req_rdy", {31'h0, req_ready}, 32'h0);
        end
        req_valid = 1'b0;
        reset     = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
        run_clear("clr2");

        access("post_lw04", 1'b0, 2'b10, 1'b0, 6'h04, 32'h0, 1'b0, 32'h0);
        access("post_lw10", 1'b0, 2'b10, 1'b0, 6'h10, 32'h0, 1'b0, 32'h0);
        access("post_lw20", 1'b0, 2'b10, 1'b0, 6'h20, 32'h0, 1'b0, 32'h0);
        access("post_lw30", 1'b0, 2'b10, 1'b0, 6'h30, 32'h0, 1'b0, 32'h0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
